// File: rtl/divider_residual_monitor.sv
// Checks each (n,d,q,r) tuple from the approximate divider array by computing the
// residual n-(q*d+r) and accumulates per-window error statistics for reporting.
module divider_residual_monitor #(
  parameter int unsigned WIN_LOG2 = 8,
  localparam int unsigned SUM_W = 17 + WIN_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_n,
  input  logic [7:0]          in_d,
  input  logic [7:0]          in_q,
  input  logic [7:0]          in_r,
  input  logic                flush,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [SUM_W-1:0]    rpt_sum,
  output logic [16:0]         rpt_max,
  output logic [WIN_LOG2:0]   rpt_errs,
  output logic [WIN_LOG2:0]   rpt_excl,
  output logic [WIN_LOG2:0]   rpt_cnt
);

  localparam int unsigned CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << WIN_LOG2) - 1);

  typedef enum logic [1:0] {COLLECT, DRAIN, REPORT} state_t;

  state_t             state;
  logic               accept;

  logic               s1_v;
  logic [15:0]        s1_n;
  logic [7:0]         s1_d;
  logic [7:0]         s1_q;
  logic [7:0]         s1_r;

  logic [16:0]        prod;
  logic signed [17:0] resid;
  logic [16:0]        resid_abs;
  logic               excl;

  logic               s2_v;
  logic [16:0]        s2_abs;
  logic               s2_excl;

  logic [CNT_W-1:0]   cnt;
  logic [SUM_W-1:0]   sum_acc;
  logic [16:0]        max_acc;
  logic [CNT_W-1:0]   errs_acc;
  logic [CNT_W-1:0]   excl_acc;

  assign accept = in_valid & in_ready;

  // S2 arithmetic: reconstruction residual and quotient-overflow exclusion
  always_comb begin
    prod      = 17'(s1_q) * 17'(s1_d) + 17'(s1_r);
    resid     = $signed({2'b00, s1_n}) - $signed({1'b0, prod});
    resid_abs = resid[17] ? 17'(-resid) : 17'(resid);
    excl      = (s1_d == 8'd0) || (s1_n[15:8] >= s1_d);
  end

  // S1 capture and S2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_n    <= '0;
      s1_d    <= '0;
      s1_q    <= '0;
      s1_r    <= '0;
      s2_v    <= 1'b0;
      s2_abs  <= '0;
      s2_excl <= 1'b0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_n <= in_n;
        s1_d <= in_d;
        s1_q <= in_q;
        s1_r <= in_r;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_abs  <= resid_abs;
        s2_excl <= excl;
      end
    end
  end

  // Window FSM, S3 accumulators and report registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      in_ready  <= 1'b1;
      rpt_valid <= 1'b0;
      rpt_sum   <= '0;
      rpt_max   <= '0;
      rpt_errs  <= '0;
      rpt_excl  <= '0;
      rpt_cnt   <= '0;
      cnt       <= '0;
      sum_acc   <= '0;
      max_acc   <= '0;
      errs_acc  <= '0;
      excl_acc  <= '0;
    end else begin
      if (s2_v) begin
        if (s2_excl) begin
          excl_acc <= excl_acc + CNT_W'(1);
        end else begin
          sum_acc  <= sum_acc + SUM_W'(s2_abs);
          errs_acc <= errs_acc + CNT_W'(s2_abs != 17'd0);
          if (s2_abs > max_acc) max_acc <= s2_abs;
        end
      end

      case (state)
        COLLECT: begin
          if (accept) cnt <= cnt + CNT_W'(1);
          if ((accept && cnt == LAST_CNT) ||
              (flush && (cnt != '0 || accept))) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          // Pipeline empty means the last accepted sample has reached the accumulators
          if (!s1_v && !s2_v) begin
            rpt_sum   <= sum_acc;
            rpt_max   <= max_acc;
            rpt_errs  <= errs_acc;
            rpt_excl  <= excl_acc;
            rpt_cnt   <= cnt;
            sum_acc   <= '0;
            max_acc   <= '0;
            errs_acc  <= '0;
            excl_acc  <= '0;
            cnt       <= '0;
            rpt_valid <= 1'b1;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (rpt_ready) begin
            rpt_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= COLLECT;
          end
        end
        default: begin
          state     <= COLLECT;
          in_ready  <= 1'b1;
          rpt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
